// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types and constants for the SDRAM request arbiter
package oric_mem_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

  localparam int MAX_CH = 4;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // Byte writes enable only the addressed lane; reads always fetch the full word.
  function automatic logic [1:0] ds_encode(input logic we, input logic a0);
    if (!we) return DS_WORD;
    return a0 ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/ram_req_chan.sv
// rtl/ram_req_chan.sv - per-client strobe edge detect and pending request slot
module ram_req_chan
  import oric_mem_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cs,
  input  logic          oe,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          clr,
  output logic          pend,
  output logic [AW-1:0] slot_addr,
  output logic          slot_we,
  output logic [7:0]    slot_din
);

  logic          rd_s, wr_s, rd_p, wr_p;
  logic [AW-1:0] addr_s, addr_p;
  logic [7:0]    din_s;
  logic          trig;

  // Client strobes are registered once, then compared against their previous value.
  assign trig = (rd_s & ~rd_p) | (wr_s & ~wr_p) | (rd_s & (addr_s != addr_p));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_s      <= 1'b0;
      wr_s      <= 1'b0;
      rd_p      <= 1'b0;
      wr_p      <= 1'b0;
      addr_s    <= '0;
      addr_p    <= '0;
      din_s     <= '0;
      pend      <= 1'b0;
      slot_addr <= '0;
      slot_we   <= 1'b0;
      slot_din  <= '0;
    end else begin
      rd_s   <= cs & oe;
      wr_s   <= cs & we;
      addr_s <= addr;
      din_s  <= din;
      rd_p   <= rd_s;
      wr_p   <= wr_s;
      addr_p <= addr_s;
      // A new trigger beats a same-cycle grant so the fresh request is not lost.
      if (trig) begin
        pend      <= 1'b1;
        slot_addr <= addr_s;
        slot_we   <= wr_s;
        slot_din  <= din_s;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_req_arbiter.sv
// rtl/ram_req_arbiter.sv - round-robin arbiter of byte clients onto one toggle-handshake SDRAM port
module ram_req_arbiter
  import oric_mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int AW     = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_cs,
  input  logic [NUM_CH-1:0]    ch_oe,
  input  logic [NUM_CH-1:0]    ch_we,
  input  logic [NUM_CH*AW-1:0] ch_addr,
  input  logic [NUM_CH*8-1:0]  ch_din,
  output logic [NUM_CH*8-1:0]  ch_q,
  output logic [NUM_CH-1:0]    ch_busy,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [AW-2:0]        mem_a,
  output logic [1:0]           mem_ds,
  output logic                 mem_we,
  output logic [15:0]          mem_d,
  input  logic [15:0]          mem_q
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pend, clr, slot_we;
  logic [AW-1:0]     slot_addr [NUM_CH];
  logic [7:0]        slot_din  [NUM_CH];

  arb_state_t  state, state_nxt;
  logic [CW-1:0] rr_ptr, grant, gnt_idx;
  logic        gnt_valid;
  logic        issue_en, done;
  logic        req_q = 1'b0;
  logic        ack_s;
  logic [15:0] q_s;
  logic        issue_a0;
  logic [7:0]  q_r [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    ram_req_chan #(.AW(AW)) u_chan (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .cs        (ch_cs[i]),
      .oe        (ch_oe[i]),
      .we        (ch_we[i]),
      .addr      (ch_addr[i*AW +: AW]),
      .din       (ch_din[i*8 +: 8]),
      .clr       (clr[i]),
      .pend      (pend[i]),
      .slot_addr (slot_addr[i]),
      .slot_we   (slot_we[i]),
      .slot_din  (slot_din[i])
    );

    assign clr[i]         = issue_en && (gnt_idx == CW'(i));
    assign ch_busy[i]     = pend[i] | ((state == WAIT) && (grant == CW'(i)));
    assign ch_q[i*8 +: 8] = q_r[i];
  end

  // Scan from rr_ptr upwards with wrap; the descending loop leaves the nearest hit.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= RESYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_en  = 1'b0;
    done      = 1'b0;
    case (state)
      RESYNC: if (ack_s == req_q) state_nxt = IDLE;
      IDLE: begin
        if (gnt_valid) begin
          issue_en  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ack_s == req_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  // mem_req deliberately survives reset so an in-flight SDRAM cycle can drain.
  always_ff @(posedge clk_sys) begin
    ack_s <= mem_ack;
    q_s   <= mem_q;
    if (issue_en) req_q <= ~req_q;
    if (reset) begin
      rr_ptr   <= '0;
      grant    <= '0;
      mem_a    <= '0;
      mem_ds   <= '0;
      mem_we   <= 1'b0;
      mem_d    <= '0;
      issue_a0 <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) q_r[i] <= '0;
    end else begin
      if (issue_en) begin
        grant    <= gnt_idx;
        rr_ptr   <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        mem_a    <= slot_addr[gnt_idx][AW-1:1];
        mem_ds   <= ds_encode(slot_we[gnt_idx], slot_addr[gnt_idx][0]);
        mem_we   <= slot_we[gnt_idx];
        mem_d    <= {slot_din[gnt_idx], slot_din[gnt_idx]};
        issue_a0 <= slot_addr[gnt_idx][0];
      end
      if (done && !mem_we) q_r[grant] <= issue_a0 ? q_s[15:8] : q_s[7:0];
    end
  end

  assign mem_req = req_q;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// tb/tb_ram_req_arbiter.sv - directed self-checking bench for ram_req_arbiter
module tb_ram_req_arbiter;

  localparam int NUM_CH = 2;
  localparam int AW     = 16;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [1:0]  ch_cs   = '0;
  logic [1:0]  ch_oe   = '0;
  logic [1:0]  ch_we   = '0;
  logic [31:0] ch_addr = '0;
  logic [15:0] ch_din  = '0;
  logic [15:0] ch_q;
  logic [1:0]  ch_busy;
  logic        mem_req;
  logic        mem_ack;
  logic [14:0] mem_a;
  logic [1:0]  mem_ds;
  logic        mem_we;
  logic [15:0] mem_d;
  logic [15:0] mem_q;

  ram_req_arbiter #(.NUM_CH(NUM_CH), .AW(AW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ch_cs   (ch_cs),
    .ch_oe   (ch_oe),
    .ch_we   (ch_we),
    .ch_addr (ch_addr),
    .ch_din  (ch_din),
    .ch_q    (ch_q),
    .ch_busy (ch_busy),
    .mem_req (mem_req),
    .mem_ack (mem_ack),
    .mem_a   (mem_a),
    .mem_ds  (mem_ds),
    .mem_we  (mem_we),
    .mem_d   (mem_d),
    .mem_q   (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          ch;
    logic [14:0] a;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
    logic        a0;
  } exp_t;

  exp_t        exp_q[$];
  int          issue_log[$];
  int          checks = 0;
  int          errors = 0;
  int          issue_count = 0;
  int          quiet = 0;
  int          ack_delay = 4;
  logic [15:0] stub_q = 16'h0000;
  logic [7:0]  model_q [NUM_CH];
  logic        last_req = 1'b0;
  int          inflight_ch = 0;
  logic        inflight_a0 = 1'b0;
  logic        inflight_rd = 1'b0;
  logic        discard = 1'b0;
  exp_t        cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected SDRAM transaction derived directly from the addressing rules.
  function automatic exp_t mk(input int ch, input logic [15:0] addr, input logic we, input logic [7:0] din);
    exp_t e;
    e.ch = ch;
    e.a  = addr[15:1];
    e.we = we;
    e.ds = we ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    e.d  = {din, din};
    e.a0 = addr[0];
    return e;
  endfunction

  // SDRAM stub: acknowledge each toggle ack_delay edges later and update the read model.
  initial begin
    mem_ack = 1'b0;
    mem_q   = 16'h0000;
    forever begin
      @(posedge clk_sys); #1;
      if (mem_req !== mem_ack) begin
        repeat (ack_delay - 1) @(posedge clk_sys);
        #1;
        mem_q   = stub_q;
        mem_ack = mem_req;
        if (inflight_rd && !discard)
          model_q[inflight_ch] = inflight_a0 ? stub_q[15:8] : stub_q[7:0];
        discard     = 1'b0;
        inflight_rd = 1'b0;
      end
    end
  end

  // Compare process: every issue against the expected queue; ch_q and ch_busy once settled.
  always @(negedge clk_sys) begin
    if (mem_req !== last_req) begin
      last_req = mem_req;
      if (exp_q.size() == 0) begin
        chk("spurious_issue", 32'd1, 32'd0);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("issue_a", 32'(mem_a), 32'(cmp_e.a));
        chk("issue_ds", 32'(mem_ds), 32'(cmp_e.ds));
        chk("issue_we", 32'(mem_we), 32'(cmp_e.we));
        if (cmp_e.we) chk("issue_d", 32'(mem_d), 32'(cmp_e.d));
        inflight_ch = cmp_e.ch;
        inflight_a0 = cmp_e.a0;
        inflight_rd = !cmp_e.we;
        issue_log.push_back(cmp_e.ch);
      end
      issue_count++;
    end
    if (reset || (mem_req !== mem_ack)) quiet = 0;
    else quiet++;
    if (quiet >= 3) begin
      for (int c = 0; c < NUM_CH; c++) chk("ch_q", 32'(ch_q[c*8 +: 8]), 32'(model_q[c]));
      if (exp_q.size() == 0) chk("idle_busy", 32'(ch_busy), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic set_write(input int ch, input logic [15:0] addr, input logic [7:0] din, input bit push);
    ch_addr[ch*16 +: 16] = addr;
    ch_din[ch*8 +: 8]    = din;
    ch_cs[ch]            = 1'b1;
    ch_we[ch]            = 1'b1;
    if (push) exp_q.push_back(mk(ch, addr, 1'b1, din));
  endtask

  task automatic end_writes();
    ch_cs = ch_cs & ch_oe;
    ch_we = '0;
  endtask

  task automatic do_write(input int ch, input logic [15:0] addr, input logic [7:0] din, input bit push);
    set_write(ch, addr, din, push);
    tick();
    end_writes();
  endtask

  task automatic set_read(input int ch, input logic [15:0] addr);
    ch_addr[ch*16 +: 16] = addr;
    ch_cs[ch]            = 1'b1;
    ch_oe[ch]            = 1'b1;
    exp_q.push_back(mk(ch, addr, 1'b0, 8'h00));
  endtask

  task automatic do_reset(input int cycles);
    if (mem_req !== mem_ack) discard = 1'b1;
    ch_cs = '0;
    ch_oe = '0;
    ch_we = '0;
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) model_q[c] = 8'h00;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  task automatic wait_issue();
    int start;
    bit seen;
    start = issue_count;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys); #1;
      if (issue_count != start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys); #1;
      if (exp_q.size() == 0 && quiet >= 4 && ch_busy == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt0;
    logic req_saved;
    for (int c = 0; c < NUM_CH; c++) model_q[c] = 8'h00;

    // Reset and idle
    do_reset(3);
    repeat (8) tick();
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_busy", 32'(ch_busy), 32'd0);
    chk("reset_ch_q", 32'(ch_q), 32'd0);

    // Single byte write on ch0
    cnt0 = issue_count;
    do_write(0, 16'h1235, 8'hA5, 1'b1);
    wait_issue();
    chk("wr_mem_a", 32'(mem_a), 32'h091A);
    chk("wr_mem_ds", 32'(mem_ds), 32'h2);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_d", 32'(mem_d), 32'hA5A5);
    wait_idle();
    chk("wr_toggles", issue_count - cnt0, 32'd1);

    // Ch1 read, then address-change re-read with oe held
    stub_q = 16'hBEEF;
    set_read(1, 16'h2000);
    wait_idle();
    chk("rd_lo_byte", 32'(ch_q[15:8]), 32'hEF);
    set_read(1, 16'h2001);
    wait_idle();
    chk("rd_hi_byte", 32'(ch_q[15:8]), 32'hBE);

    // Simultaneous triggers from rr_ptr=0, then from rr_ptr=1
    do_reset(2);
    issue_log.delete();
    set_write(0, 16'h0100, 8'h01, 1'b1);
    set_write(1, 16'h0200, 8'h02, 1'b1);
    tick();
    end_writes();
    wait_idle();
    chk("rr0_count", issue_log.size(), 32'd2);
    if (issue_log.size() == 2) begin
      chk("rr0_first", issue_log[0], 32'd0);
      chk("rr0_second", issue_log[1], 32'd1);
    end
    do_write(0, 16'h0300, 8'h03, 1'b1);
    wait_idle();
    issue_log.delete();
    set_write(1, 16'h0402, 8'h42, 1'b1);
    set_write(0, 16'h0501, 8'h51, 1'b1);
    tick();
    end_writes();
    wait_idle();
    chk("rr1_count", issue_log.size(), 32'd2);
    if (issue_log.size() == 2) begin
      chk("rr1_first", issue_log[0], 32'd1);
      chk("rr1_second", issue_log[1], 32'd0);
    end

    // Two ch0 writes while ch1 holds the port: last one wins
    ack_delay = 8;
    stub_q    = 16'h5A69;
    set_read(1, 16'h3000);
    wait_issue();
    cnt0 = issue_count;
    do_write(0, 16'h0010, 8'h11, 1'b0);
    tick();
    do_write(0, 16'h0010, 8'h22, 1'b1);
    chk("ovw_busy", 32'(ch_busy[0]), 32'd1);
    chk("ovw_in_flight", 32'(mem_req != mem_ack), 32'd1);
    wait_idle();
    chk("ovw_toggles", issue_count - cnt0, 32'd1);
    chk("ovw_rd_byte", 32'(ch_q[15:8]), 32'h69);

    // Reset during WAIT: late ack drained and dropped, then a normal read
    do_reset(2);
    ack_delay = 6;
    stub_q    = 16'hC3D4;
    set_read(0, 16'h0040);
    wait_issue();
    tick();
    ch_cs[0] = 1'b0;
    ch_oe[0] = 1'b0;
    do_reset(1);
    req_saved = mem_req;
    set_read(0, 16'h0041);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_sys); #1;
      if (mem_req === mem_ack) break;
    end
    chk("resync_hold", 32'(mem_req), 32'(req_saved));
    tick();
    tick();
    chk("late_read_dropped", 32'(ch_q[7:0]), 32'h00);
    wait_idle();
    chk("post_reset_read", 32'(ch_q[7:0]), 32'hC3);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
